add_share_arb: RTL
==================

Name: add_share_arb

Overview:
Round-robin arbiter and sequencer that shares the single 8-bit operand adder among NUM_REQ requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester per issue tick, computes the sum in a registered stage, and returns it with the requester ID over a valid/ready response port. Issue pacing uses a clock-enable divider, not a derived clock, so the whole block runs in a single clock domain.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 8, operand width; the sum is WIDTH+1 bits.
- DIV, 2, issue tick period in clk cycles (1 = every cycle).

Ports:
- clk  in  1  system clock; everything is posedge clk.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  in  NUM_REQ*WIDTH  operand A; requester i uses slice [i*WIDTH +: WIDTH].
- req_b  in  NUM_REQ*WIDTH  operand B; same slicing.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  result consumer ready.
- rsp_id  out  $clog2(NUM_REQ)  index of the granted requester.
- rsp_sum  out  WIDTH+1  result.
- busy  out  1  high when the FSM is not in IDLE.

Behaviour:
- Reset (asynchronous, rst=1):
  - state=IDLE, tick counter=0, rr pointer=0.
  - rsp_valid=0, rsp_id=0, rsp_sum=0, busy=0.
  - Operand registers are cleared.
  - A transaction in flight is discarded; no response is produced after reset.
- Tick divider:
  - Counter runs 0..DIV-1 continuously, independent of state.
  - tick=1 when counter==DIV-1.
  - DIV=1 gives tick=1 every cycle.
- Round-robin grant (combinational):
  - Search req_valid starting at index ptr, wrapping at NUM_REQ-1 back to 0.
  - The first asserted index is the grant g.
- FSM states: IDLE, CALC, RESP.
  - IDLE: if tick and any req_valid: req_ready[g]=1 for exactly this cycle. Capture a, b and g; set ptr = (g+1) mod NUM_REQ; go to CALC. Otherwise req_ready=0 and ptr holds.
  - CALC (1 cycle): rsp_sum <= zero-extended a + b (WIDTH+1 bits, no wrap), rsp_id <= g, rsp_valid <= 1; go to RESP.
  - RESP: hold rsp_valid, rsp_id and rsp_sum stable until rsp_ready=1. On rsp_valid && rsp_ready, rsp_valid is 0 next cycle and the state returns to IDLE.
- Latency and throughput:
  - Grant cycle T gives rsp_valid=1 at T+2.
  - If rsp_ready is held high, the next grant comes on the first tick at or after T+3.
- req_ready is 0 in CALC and RESP; grants are never issued while a result is pending.
- Requester rule: req_valid and operands are held until ready. The arbiter does not check this; the bench flags violations.
- Simultaneous requests: exactly one grant per tick. A requester at ptr wins over the others.
- rsp_ready already high when rsp_valid rises: the handshake completes in the first RESP cycle.
- busy = (state != IDLE).

Optional Feature:
- Macro: ADD_SHARE_ARB_SAT_EN.
- Defined:
  - rsp_sum[WIDTH] is a carry/overflow flag.
  - rsp_sum[WIDTH-1:0] saturates to all ones when the carry is set.
  - Example: 200+100 gives {1, 8'hFF}.
- Undefined: rsp_sum is the raw WIDTH+1-bit sum (200+100 gives 9'd300).
- Handshake, latency and reset are identical in both builds.

Decomposition:
- Package add_share_arb_pkg:
  - state enum {IDLE, CALC, RESP}.
  - Default WIDTH and NUM_REQ constants.
  - Function for the ID width ($clog2 with a minimum of 1).
- Sub-module rr_grant: combinational round-robin picker.
  - Inputs: req vector, ptr.
  - Outputs: grant index, any_req.
- The FSM, tick divider and adder stay in add_share_arb.

Test Plan:
1. Reset mid-RESP (rsp_ready=0, rsp_valid=1), pulse rst -> rsp_valid=0, busy=0 and ptr=0 immediately (asynchronously). The next grant goes to the lowest valid index.
2. DIV=2, only req0 valid with a=12, b=30, rsp_ready=1 -> req_ready[0] on a tick cycle T; rsp_valid, rsp_id=0 and rsp_sum=42 at T+2.
3. All 4 requesters valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0,…; sums match each requester's operands.
4. Backpressure: rsp_ready=0 for 10 cycles after rsp_valid -> rsp_sum and rsp_id stable, no req_ready pulses. rsp_ready=1 -> exactly one handshake, then the next grant.
5. Overflow: a=200, b=100 -> 9'd300 without the macro; {1, 8'hFF} with ADD_SHARE_ARB_SAT_EN defined.
6. DIV=1 vs DIV=3, single requester always valid, rsp_ready=1 -> grant cycles spaced 3 apart (DIV=1) and 3 apart aligned to ticks (DIV=3). No grant ever appears on a non-tick cycle.

Source files
------------

// File: rtl/add_share_arb_pkg.sv
// Shared types and constants for the adder-sharing round-robin arbiter.
// Optional saturating result: define ADD_SHARE_ARB_SAT_EN.
package add_share_arb_pkg;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_NUM_REQ = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/add_share_arb_if.sv
// Requester and response handshake bundle for add_share_arb.
// master = requesters/consumer side, slave = arbiter side.
interface add_share_arb_if
    import add_share_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int WIDTH   = DEF_WIDTH
);

    localparam int IDW = id_w(NUM_REQ);

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [IDW-1:0]           rsp_id;
    logic [WIDTH:0]           rsp_sum;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum
    );

endinterface

// File: rtl/add_share_arb_rr_grant.sv
// Combinational round-robin picker: first asserted request at or after ptr.
// Part of add_share_arb (optional macro ADD_SHARE_ARB_SAT_EN unused here).
module rr_grant
    import add_share_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDW     = id_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic [IDW-1:0]     grant,
    output logic               any_req
);

    // Rotating a doubled copy puts requester ptr at bit 0.
    logic [2*NUM_REQ-1:0] rot;

    assign rot = {req, req} >> ptr;

    always_comb begin
        grant   = '0;
        any_req = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!any_req && rot[i]) begin
                any_req = 1'b1;
                grant   = IDW'((int'(ptr) + i) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/add_share_arb.sv
// Round-robin arbiter sharing one registered adder among NUM_REQ requesters.
// Define ADD_SHARE_ARB_SAT_EN for carry flag plus saturated low bits.
module add_share_arb
    import add_share_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int DIV     = 2
) (
    input  logic           clk,
    input  logic           rst,
    add_share_arb_if.slave bus,
    output logic           busy
);

    localparam int IDW = id_w(NUM_REQ);
    localparam int CW  = id_w(DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IDW-1:0]       ptr_q, ptr_d;
    logic [IDW-1:0]       gid_q, gid_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]       rsp_id_q, rsp_id_d;
    logic [WIDTH:0]       rsp_sum_q, rsp_sum_d;
    logic [WIDTH:0]       sum_raw, sum_res;
    logic [NUM_REQ-1:0]   rdy;
    logic [IDW-1:0]       grant;
    logic                 any_req;
    logic                 tick;

    rr_grant #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_rr (
        .req     (bus.req_valid),
        .ptr     (ptr_q),
        .grant   (grant),
        .any_req (any_req)
    );

    assign tick    = (cnt_q == CNT_LAST);
    assign sum_raw = {1'b0, a_q} + {1'b0, b_q};

`ifdef ADD_SHARE_ARB_SAT_EN
    assign sum_res = sum_raw[WIDTH] ? {1'b1, {WIDTH{1'b1}}} : sum_raw;
`else
    assign sum_res = sum_raw;
`endif

    always_comb begin
        cnt_d       = tick ? '0 : cnt_q + 1'b1;
        state_d     = state_q;
        ptr_d       = ptr_q;
        gid_d       = gid_q;
        a_d         = a_q;
        b_d         = b_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_sum_d   = rsp_sum_q;
        rdy         = '0;
        unique case (state_q)
            IDLE: begin
                if (tick && any_req) begin
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (grant == IDW'(i)) begin
                            rdy[i] = 1'b1;
                            a_d    = bus.req_a[i*WIDTH +: WIDTH];
                            b_d    = bus.req_b[i*WIDTH +: WIDTH];
                        end
                    end
                    gid_d   = grant;
                    ptr_d   = (int'(grant) == NUM_REQ - 1) ? '0 : grant + 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                rsp_sum_d   = sum_res;
                rsp_id_d    = gid_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ptr_q       <= '0;
            gid_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            gid_q       <= gid_d;
            a_q         <= a_d;
            b_q         <= b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_sum_q   <= rsp_sum_d;
        end
    end

    assign bus.req_ready = rdy;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_sum   = rsp_sum_q;
    assign busy          = (state_q != IDLE);

endmodule
